bit_scanner: RTL and testbench

BIT_SCANNER -- requirements
Module: bit_scanner

---
 rtl/bit_scanner.sv | 101 ++++++++++
 tb/tb_bit_scanner.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/bit_scanner.sv
// Serial bit scanner: popcount, trailing ones from the LSB or leading ones from
// the MSB, examining one operand bit per cycle with early exit for run counts.
module bit_scanner #(
  parameter int W  = 7,
  parameter int CW = $clog2(W + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   sel,
  input  logic [W-1:0] sw,
  output logic [W-1:0] led,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  opnd;
  logic [1:0]    mode;
  logic [CW-1:0] cnt;
  logic [CW-1:0] idx;

  logic          exam_bit;
  logic [CW-1:0] cnt_sum;
  logic          is_last;
  logic          run_mode;
  logic          term;

  // Loop-based select keeps the index width independent of W.
  function automatic logic pick_bit(input logic [W-1:0] op, input logic [1:0] md,
                                    input logic [CW-1:0] ix);
    logic b;
    b = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (md == 2'b10) begin
        if (ix == CW'(W - 1 - i)) b = op[i];
      end else begin
        if (ix == CW'(i)) b = op[i];
      end
    end
    return b;
  endfunction

  always_comb begin
    exam_bit  = pick_bit(opnd, mode, idx);
    cnt_sum   = cnt + CW'(exam_bit);
    is_last   = (idx == CW'(W - 1));
    run_mode  = (mode == 2'b01) || (mode == 2'b10);
    term      = run_mode ? (!exam_bit || is_last) : is_last;
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (term) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd <= '0;
      mode <= '0;
      cnt  <= '0;
      idx  <= '0;
      led  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opnd <= sw;
            mode <= sel;
            cnt  <= '0;
            idx  <= '0;
          end
        end
        SCAN: begin
          cnt <= cnt_sum;
          idx <= idx + CW'(1);
          // Final count includes the bit examined on the terminating edge.
          if (term) led <= W'(cnt_sum);
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_bit_scanner.sv
// Directed bench for bit_scanner (W=7): result values, done latency, start
// masking, input isolation after capture and asynchronous reset mid-scan.
module tb_bit_scanner;
  localparam int W = 7;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   sel;
  logic [W-1:0] sw;
  logic [W-1:0] led;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  bit_scanner #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sel(sel), .sw(sw),
    .led(led), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Start a scan, scramble the inputs after capture, and measure done latency.
  task automatic run(input string tag, input logic [1:0] s, input logic [W-1:0] v,
                     input int exp_led, input int exp_lat);
    int   n;
    bit   got;
    bit   held;
    logic [W-1:0] prev;
    @(negedge clk);
    prev  = led;
    sel   = s;
    sw    = v;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sw    = ~v;
    sel   = ~s;
    check({tag, "_busy_e0"}, 32'(busy), 1);
    n = 0; got = 1'b0; held = 1'b1;
    while (n < 20 && !got) begin
      @(posedge clk); #1;
      n++;
      if (done) got = 1'b1;
      else if (led !== prev) held = 1'b0;
    end
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_led"}, 32'(led), exp_led);
    check({tag, "_led_held"}, 32'(held), 1);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(done), 0);
    check({tag, "_busy_end"}, 32'(busy), 0);
  endtask

  initial begin
    int           ndone;
    int           first;
    bit           no_done;
    logic [W-1:0] snap;

    rst_n = 1'b0; start = 1'b0; sel = 2'b00; sw = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_led", 32'(led), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    @(negedge clk); rst_n = 1'b1;

    run("pop",        2'b00, 7'b1011001, 4, 7);
    // Idle with start low: led holds, not busy.
    repeat (3) @(posedge clk);
    #1;
    check("idle_hold_led", 32'(led), 4);
    check("idle_busy", 32'(busy), 0);

    run("tr_0000111", 2'b01, 7'b0000111, 3, 4);
    run("tr_1111111", 2'b01, 7'b1111111, 7, 7);
    run("tr_0000000", 2'b01, 7'b0000000, 0, 1);
    run("ld_1100000", 2'b10, 7'b1100000, 2, 3);
    run("m11_1100000", 2'b11, 7'b1100000, 2, 7);
    run("ld_1111111", 2'b10, 7'b1111111, 7, 7);
    run("ld_0111111", 2'b10, 7'b0111111, 0, 1);
    run("pop_zero",   2'b00, 7'b0000000, 0, 7);
    run("tr_1011111", 2'b01, 7'b1011111, 5, 6);

    // Second start two cycles after E0 must be ignored.
    @(negedge clk);
    sel = 2'b00; sw = 7'b0000001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; first = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 2) begin
        sw = 7'b1111111; start = 1'b1;
      end
      @(posedge clk); #1;
      if (c == 3) start = 1'b0;
      if (done) begin
        ndone++;
        if (first == 0) first = c;
      end
    end
    start = 1'b0;
    check("restart_ignored_led", 32'(led), 1);
    check("restart_ndone", ndone, 1);
    check("restart_latency", first, 7);

    // Load a nonzero result, then reset in the middle of a scan.
    run("pre_rst", 2'b00, 7'b1111110, 6, 7);
    @(negedge clk);
    sel = 2'b00; sw = 7'b1111111; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_done", 32'(done), 0);
    check("arst_led", 32'(led), 0);
    no_done = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (done || busy) no_done = 1'b0;
    end
    check("arst_no_done", 32'(no_done), 1);
    snap = led;
    check("arst_led_still0", 32'(snap), 0);
    @(negedge clk); rst_n = 1'b1;
    run("post_rst", 2'b00, 7'b0101010, 3, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
